// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Single-port RAM arbiter that sits below the instruction and data caches.
// Only one cache is granted the RAM at a time. The data side normally wins.
// A starvation counter forces an instruction grant after ISTARVE_MAX
// consecutive data completions while an instruction fill is waiting.
//
// Handshake: a cache raises its request (iREN, or dREN/dWEN) and holds it
// until its wait output drops. The wait output is 0 for exactly one cycle,
// which is the cycle in which the granted access sees ramstate==ACCESS. That
// one-cycle low is both "done" and "load data valid". If a request drops
// before ACCESS, the grant is abandoned and no wait pulse is issued.
//
// Ports
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN, iaddr          icache fill request and word address
//   iwait, iload         icache wait handshake and returned instruction word
//   dREN, dWEN           dcache read / write request (both set = write)
//   daddr, dstore        dcache address and write data
//   dwait, dload         dcache wait handshake and returned data word
//   ramREN, ramWEN       RAM read / write enables
//   ramaddr, ramstore    RAM address and write data
//   ramload              RAM read data
//   ramstate             0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//   dbg_state            current FSM state (0 IDLE, 1 DGRANT, 2 IGRANT)
//   dbg_starve_cnt       current instruction-starvation count
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int WORD_W      = 32,
   parameter int ISTARVE_MAX = 4,
   localparam int CNT_W      = $clog2(ISTARVE_MAX + 1)
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [WORD_W-1:0] iaddr,
   output logic              iwait,
   output logic [WORD_W-1:0] iload,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [WORD_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic              dwait,
   output logic [WORD_W-1:0] dload,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [WORD_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic [1:0]        dbg_state,
   output logic [CNT_W-1:0]  dbg_starve_cnt
);

   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DGRANT = 2'd1,
      IGRANT = 2'd2
   } state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] starve_cnt;

   logic d_req;
   logic access;
   logic i_starved;

   assign d_req     = dREN | dWEN;
   assign access    = (ramstate == RAM_ACCESS);
   assign i_starved = iREN && (starve_cnt == CNT_W'(ISTARVE_MAX));

   // State register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. Every grant ends by going back to IDLE, on completion
   // or on withdrawal, so consecutive grants always have one idle cycle
   // between them.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (d_req && !i_starved)  next_state = DGRANT;
            else if (iREN)            next_state = IGRANT;
            else                      next_state = IDLE;
         end
         DGRANT: begin
            if (!d_req || access)     next_state = IDLE;
         end
         IGRANT: begin
            if (!iREN || access)      next_state = IDLE;
         end
         default:                     next_state = IDLE;
      endcase
   end

   // Output decode. No RAM signal is driven in IDLE. A withdrawn request
   // drops the enables in the same cycle and gets no wait pulse.
   always_comb begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      unique case (state)
         DGRANT: begin
            if (d_req) begin
               ramaddr  = daddr;
               ramstore = dstore;
               ramWEN   = dWEN;
               ramREN   = dREN & ~dWEN;
               dwait    = ~access;
            end
         end
         IGRANT: begin
            if (iREN) begin
               ramaddr = iaddr;
               ramREN  = 1'b1;
               iwait   = ~access;
            end
         end
         default: ;
      endcase
   end

   assign iload = ramload;
   assign dload = ramload;

   // Starvation counter. It only counts data completions that an instruction
   // fill actually waited through. It clears as soon as the fill is served or
   // withdrawn.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         starve_cnt <= '0;
      end else if (!iREN) begin
         starve_cnt <= '0;
      end else if (state == DGRANT && d_req && access) begin
         if (starve_cnt != CNT_W'(ISTARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
      end else if (state == IGRANT && access) begin
         starve_cnt <= '0;
      end
   end

   assign dbg_state      = state;
   assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. It runs directed scenarios and then
// random traffic. A cycle-level reference model tracks who owns the RAM and
// the starvation count, and predicts every output.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int W    = 32;
   localparam int SMAX = 4;
   localparam int CW   = $clog2(SMAX + 1);

   localparam logic [1:0] RS_FREE   = 2'd0;
   localparam logic [1:0] RS_BUSY   = 2'd1;
   localparam logic [1:0] RS_ACCESS = 2'd2;
   localparam logic [1:0] RS_ERROR  = 2'd3;

   logic          CLK = 1'b0;
   logic          nRST;
   logic          iREN, dREN, dWEN;
   logic [W-1:0]  iaddr, daddr, dstore, ramload;
   logic [1:0]    ramstate;
   logic          iwait, dwait, ramREN, ramWEN;
   logic [W-1:0]  iload, dload, ramaddr, ramstore;
   logic [1:0]    dbg_state;
   logic [CW-1:0] dbg_starve_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: who holds the RAM (0 none, 1 dcache, 2 icache), the
   // starvation count, and a completion log for the directed checks.
   int owner;
   int scnt;
   int d_done, i_done;

   logic [W-1:0] exp_q[$];

   mem_arbiter #(.WORD_W(W), .ISTARVE_MAX(SMAX)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
   );

   // clock / reset block
   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [W-1:0] got,
                            input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      #1;
      owner = 0;
      scnt  = 0;
      check_val("rst_iwait",  W'(iwait),  W'(1));
      check_val("rst_dwait",  W'(dwait),  W'(1));
      check_val("rst_ramREN", W'(ramREN), W'(0));
      check_val("rst_ramWEN", W'(ramWEN), W'(0));
      check_val("rst_addr",   ramaddr,    '0);
      check_val("rst_store",  ramstore,   '0);
      check_val("rst_starve", W'(dbg_starve_cnt), W'(0));
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   // One cycle: drive inputs after the falling edge, check outputs against the
   // model, then advance the model to what the next rising edge should do.
   task automatic step(input logic i_r, input logic d_r, input logic d_w,
                       input logic [1:0] rs);
      logic         e_iw, e_dw, e_ren, e_wen, dq;
      logic [W-1:0] e_addr, e_store;
      int           n_owner;
      @(negedge CLK);
      iREN = i_r; dREN = d_r; dWEN = d_w; ramstate = rs;
      iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
      #1;
      dq = d_r | d_w;
      e_iw = 1'b1; e_dw = 1'b1; e_ren = 1'b0; e_wen = 1'b0;
      e_addr = '0; e_store = '0;
      if (owner == 1 && dq) begin
         e_addr = daddr; e_store = dstore;
         e_wen = d_w; e_ren = d_r && !d_w;
         e_dw = (rs != RS_ACCESS);
      end else if (owner == 2 && i_r) begin
         e_addr = iaddr; e_ren = 1'b1;
         e_iw = (rs != RS_ACCESS);
      end
      check_val("iwait",  W'(iwait),  W'(e_iw));
      check_val("dwait",  W'(dwait),  W'(e_dw));
      check_val("ramREN", W'(ramREN), W'(e_ren));
      check_val("ramWEN", W'(ramWEN), W'(e_wen));
      check_val("ramaddr",  ramaddr,  e_addr);
      check_val("ramstore", ramstore, e_store);
      exp_q.push_back(ramload);
      check_val("iload", iload, exp_q[$]);
      check_val("dload", dload, exp_q.pop_back());
      check_val("starve", W'(dbg_starve_cnt), W'(scnt));
      if (!e_dw) d_done++;
      if (!e_iw) i_done++;
      // advance model
      if (owner == 0) begin
         if (dq && !(i_r && scnt == SMAX)) n_owner = 1;
         else if (i_r)                     n_owner = 2;
         else                              n_owner = 0;
      end else if (owner == 1) begin
         n_owner = (dq && rs != RS_ACCESS) ? 1 : 0;
      end else begin
         n_owner = (i_r && rs != RS_ACCESS) ? 2 : 0;
      end
      if (!i_r)                                      scnt = 0;
      else if (owner == 1 && dq && rs == RS_ACCESS)  scnt = (scnt < SMAX) ? scnt + 1 : SMAX;
      else if (owner == 2 && rs == RS_ACCESS)        scnt = 0;
      owner = n_owner;
   endtask

   initial begin
      int data_before_i;
      nRST = 1'b1; iREN = 0; dREN = 0; dWEN = 0; ramstate = RS_FREE;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
      d_done = 0; i_done = 0;
      do_reset();

      // 1: instruction fill completing on the 3rd grant cycle
      step(1, 0, 0, RS_FREE);
      step(1, 0, 0, RS_BUSY);
      step(1, 0, 0, RS_BUSY);
      i_done = 0;
      @(negedge CLK);
      iREN = 1; iaddr = 32'h40; ramload = 32'hDEADBEEF; ramstate = RS_ACCESS;
      #1;
      check_val("t1_iwait", W'(iwait), W'(0));
      check_val("t1_iload", iload, 32'hDEADBEEF);
      check_val("t1_addr",  ramaddr, 32'h40);
      check_val("t1_ren",   W'(ramREN), W'(1));
      owner = 0;
      step(0, 0, 0, RS_FREE);
      check_val("t1_after", W'(iwait), W'(1));

      // 2: simultaneous requests; data first, then instruction
      d_done = 0; i_done = 0;
      step(1, 1, 0, RS_FREE);
      step(1, 1, 0, RS_ACCESS);
      check_val("t2_dfirst", W'(d_done), W'(1));
      step(1, 0, 0, RS_FREE);
      step(1, 0, 0, RS_ACCESS);
      check_val("t2_ithen", W'(i_done), W'(1));
      step(0, 0, 0, RS_FREE);

      // 3: starvation; data continuously requested while a fill waits
      d_done = 0; i_done = 0; data_before_i = -1;
      for (int c = 0; c < 40; c++) begin
         step(1, 1, c[0], RS_ACCESS);
         if (i_done != 0 && data_before_i < 0) data_before_i = d_done;
      end
      check_val("t3_data_before_i", W'(data_before_i), W'(SMAX));
      step(0, 0, 0, RS_FREE);

      // 4: simultaneous dREN/dWEN treated as a write
      step(0, 1, 1, RS_FREE);
      @(negedge CLK);
      dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'h1234; ramstate = RS_ACCESS;
      #1;
      check_val("t4_wen",   W'(ramWEN), W'(1));
      check_val("t4_ren",   W'(ramREN), W'(0));
      check_val("t4_store", ramstore, 32'h1234);
      check_val("t4_addr",  ramaddr, 32'h100);
      check_val("t4_dwait", W'(dwait), W'(0));
      owner = 0;
      step(0, 0, 0, RS_FREE);

      // 5: ERROR retried until ACCESS, with a fill pending throughout
      d_done = 0; i_done = 0;
      step(1, 1, 0, RS_FREE);
      for (int c = 0; c < 5; c++) step(1, 1, 0, RS_ERROR);
      check_val("t5_no_pulse", W'(d_done + i_done), W'(0));
      step(1, 1, 0, RS_ACCESS);
      check_val("t5_dpulse", W'(d_done), W'(1));
      check_val("t5_ipulse", W'(i_done), W'(0));
      step(0, 0, 0, RS_FREE);

      // 6: reset during a busy instruction grant
      step(1, 0, 0, RS_FREE);
      step(1, 0, 0, RS_BUSY);
      nRST = 1'b0;
      #1;
      check_val("t6_ren",   W'(ramREN), W'(0));
      check_val("t6_iwait", W'(iwait), W'(1));
      owner = 0; scnt = 0;
      @(negedge CLK);
      check_val("t6_starve", W'(dbg_starve_cnt), W'(0));
      check_val("t6_ren2",   W'(ramREN), W'(0));
      nRST = 1'b1;
      step(0, 0, 0, RS_FREE);

      // random traffic, including withdrawals and all RAM states
      for (int c = 0; c < 600; c++) begin
         step($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 5,
              $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard time limit
   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $fatal(1);
   end

endmodule
